// File: rtl/scan_pkg.sv
// Shared scan-path definitions: frame size, scan-mode codes, writer states.
// The mode codes are common to the scan counter and the edge-map writer.
package scan_pkg;

    localparam int N_DEF = 150;
    localparam int NPIX  = N_DEF * N_DEF;

    typedef enum logic [1:0] {
        LR = 2'b00,
        UD = 2'b01,
        DL = 2'b10,
        DR = 2'b11
    } scan_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } wr_state_t;

endpackage

// File: rtl/scan_pos_step.sv
// Next scan position for the edge-map writer; purely combinational.
// Line starts come from the line index and a per-line base address.
module scan_pos_step
    import scan_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int ADDR_W = 15,
    parameter int RW     = (N > 1) ? $clog2(N) : 1,
    parameter int LW     = $clog2(2 * N)
) (
    input  scan_mode_t        i_mode,
    input  logic [RW-1:0]     i_row,
    input  logic [RW-1:0]     i_col,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [ADDR_W-1:0] i_lineAddr,
    input  logic [LW-1:0]     i_line,
    output logic [RW-1:0]     o_row,
    output logic [RW-1:0]     o_col,
    output logic [ADDR_W-1:0] o_addr,
    output logic [ADDR_W-1:0] o_lineAddr,
    output logic [LW-1:0]     o_line,
    output logic              o_lastInLine,
    output logic              o_lastInFrame
);

    localparam logic [RW-1:0]     RMAX  = RW'(N - 1);
    localparam logic [LW-1:0]     LMAXS = LW'(N - 1);
    localparam logic [LW-1:0]     LMAXD = LW'(2 * N - 2);
    localparam logic [ADDR_W-1:0] A1    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] AN    = ADDR_W'(N);

    logic [LW-1:0]     w_nl;
    logic [RW-1:0]     w_nlRC;
    logic [RW-1:0]     w_nlOff;
    logic              w_nlLow;
    logic              w_lastRow;
    logic              w_lastCol;
    logic              w_firstCol;
    logic [LW-1:0]     w_lastLine;
    logic [RW-1:0]     w_stRow;
    logic [RW-1:0]     w_stCol;
    logic [ADDR_W-1:0] w_stAddr;
    logic [RW-1:0]     w_sRow;
    logic [RW-1:0]     w_sCol;
    logic [ADDR_W-1:0] w_sAddr;

    assign w_nl       = i_line + 1'b1;
    assign w_nlRC     = RW'(w_nl);
    // Second-half diagonals start on row (line - N + 1).
    assign w_nlOff    = RW'(w_nl - LMAXS);
    assign w_nlLow    = (w_nl <= LMAXS);
    assign w_lastRow  = (i_row == RMAX);
    assign w_lastCol  = (i_col == RMAX);
    assign w_firstCol = (i_col == '0);

    always_comb begin
        w_stRow      = i_row;
        w_stCol      = i_col;
        w_stAddr     = i_addr;
        w_sRow       = '0;
        w_sCol       = '0;
        w_sAddr      = i_lineAddr;
        w_lastLine   = LMAXS;
        o_lastInLine = 1'b0;
        unique case (i_mode)
            LR: begin
                w_stCol      = i_col + 1'b1;
                w_stAddr     = i_addr + A1;
                w_sRow       = w_nlRC;
                w_sAddr      = i_lineAddr + AN;
                o_lastInLine = w_lastCol;
            end
            UD: begin
                w_stRow      = i_row + 1'b1;
                w_stAddr     = i_addr + AN;
                w_sCol       = w_nlRC;
                w_sAddr      = i_lineAddr + A1;
                o_lastInLine = w_lastRow;
            end
            DL: begin
                w_stRow      = i_row + 1'b1;
                w_stCol      = i_col - 1'b1;
                w_stAddr     = i_addr + AN - A1;
                w_sRow       = w_nlLow ? '0 : w_nlOff;
                w_sCol       = w_nlLow ? w_nlRC : RMAX;
                w_sAddr      = w_nlLow ? i_lineAddr + A1 : i_lineAddr + AN;
                w_lastLine   = LMAXD;
                o_lastInLine = w_firstCol || w_lastRow;
            end
            DR: begin
                w_stRow      = i_row + 1'b1;
                w_stCol      = i_col + 1'b1;
                w_stAddr     = i_addr + AN + A1;
                w_sRow       = w_nlLow ? '0 : w_nlOff;
                w_sCol       = w_nlLow ? RMAX - w_nlRC : '0;
                w_sAddr      = w_nlLow ? i_lineAddr - A1 : i_lineAddr + AN;
                w_lastLine   = LMAXD;
                o_lastInLine = w_lastRow || w_lastCol;
            end
        endcase
    end

    assign o_lastInFrame = o_lastInLine && (i_line == w_lastLine);
    assign o_line        = o_lastInLine ? w_nl : i_line;
    assign o_row         = o_lastInLine ? w_sRow : w_stRow;
    assign o_col         = o_lastInLine ? w_sCol : w_stCol;
    assign o_addr        = o_lastInLine ? w_sAddr : w_stAddr;
    assign o_lineAddr    = o_lastInLine ? w_sAddr : i_lineAddr;

endmodule

// File: rtl/edge_map_writer.sv
// Writes scan-ordered edge bits to their linear pixel address in the edge map.
// FSM, position registers and a one-cycle registered write port.
module edge_map_writer
    import scan_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              resetIn,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic              inValid,
    input  logic              inEdge,
    output logic              inReady,
    output logic              wrEn,
    output logic [ADDR_W-1:0] wrAddr,
    output logic              wrData,
    output logic              lineEnd,
    output logic              busy,
    output logic              done
);

    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int LW = $clog2(2 * N);
    localparam logic [RW-1:0]     RMAX = RW'(N - 1);
    localparam logic [ADDR_W-1:0] AMAX = ADDR_W'(N - 1);

    wr_state_t         r_state;
    wr_state_t         w_next;
    scan_mode_t        r_mode;
    logic [RW-1:0]     r_row;
    logic [RW-1:0]     r_col;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_lineAddr;
    logic [LW-1:0]     r_line;
    logic              r_wrEn;
    logic [ADDR_W-1:0] r_wrAddr;
    logic              r_wrData;
    logic              r_lineEnd;

    logic [RW-1:0]     w_row;
    logic [RW-1:0]     w_col;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_lineAddr;
    logic [LW-1:0]     w_line;
    logic              w_lastInLine;
    logic              w_lastInFrame;
    logic              w_xfer;
    logic              w_startOk;
    logic              w_isDR;

    assign w_xfer    = inValid && (r_state == SCAN);
    assign w_startOk = start && (r_state == IDLE);
    assign w_isDR    = (mode == DR);

    scan_pos_step #(
        .N      (N),
        .ADDR_W (ADDR_W),
        .RW     (RW),
        .LW     (LW)
    ) u_step (
        .i_mode        (r_mode),
        .i_row         (r_row),
        .i_col         (r_col),
        .i_addr        (r_addr),
        .i_lineAddr    (r_lineAddr),
        .i_line        (r_line),
        .o_row         (w_row),
        .o_col         (w_col),
        .o_addr        (w_addr),
        .o_lineAddr    (w_lineAddr),
        .o_line        (w_line),
        .o_lastInLine  (w_lastInLine),
        .o_lastInFrame (w_lastInFrame)
    );

    always_ff @(posedge clk) begin
        if (resetIn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = SCAN;
            SCAN:    if (w_xfer && w_lastInFrame) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Line 0 starts at the top-left corner except in DR (top-right).
    always_ff @(posedge clk) begin
        if (resetIn) begin
            r_mode     <= LR;
            r_row      <= '0;
            r_col      <= '0;
            r_addr     <= '0;
            r_lineAddr <= '0;
            r_line     <= '0;
        end else if (w_startOk) begin
            r_mode     <= scan_mode_t'(mode);
            r_row      <= '0;
            r_col      <= w_isDR ? RMAX : '0;
            r_addr     <= w_isDR ? AMAX : '0;
            r_lineAddr <= w_isDR ? AMAX : '0;
            r_line     <= '0;
        end else if (w_xfer) begin
            r_row      <= w_row;
            r_col      <= w_col;
            r_addr     <= w_addr;
            r_lineAddr <= w_lineAddr;
            r_line     <= w_line;
        end
    end

    always_ff @(posedge clk) begin
        if (resetIn) begin
            r_wrEn    <= 1'b0;
            r_wrAddr  <= '0;
            r_wrData  <= 1'b0;
            r_lineEnd <= 1'b0;
        end else begin
            r_wrEn    <= w_xfer;
            r_lineEnd <= w_xfer && w_lastInLine;
            if (w_xfer) begin
                r_wrAddr <= r_addr;
                r_wrData <= inEdge;
            end
        end
    end

    assign inReady = (r_state == SCAN);
    assign busy    = (r_state == SCAN);
    assign done    = (r_state == DONE);
    assign wrEn    = r_wrEn;
    assign wrAddr  = r_wrAddr;
    assign wrData  = r_wrData;
    assign lineEnd = r_lineEnd;

endmodule

// File: doc/edge_map_writer.md
# edge_map_writer

Writeback end of the image scan path. The scan counter drives pixel indices into the edge detector. This block accepts the detector's per-pixel edge results in scan order and writes each bit to the linear address of the pixel it belongs to in the edge-map RAM. It reconstructs addresses for all four scan modes (LR, UD, DL, DR), marks line boundaries, and signals completion of a full frame.

## Interface
- N, default 150: image side length, square N×N image.
- ADDR_W, default 15: address width; must satisfy 2^ADDR_W ≥ N·N.
- clk, input, 1: rising-edge clock.
- resetIn, input, 1: synchronous, active-high reset.
- mode, input, 2: scan mode, sampled only on an accepted start. 00 = LR, 01 = UD, 10 = DL, 11 = DR.
- start, input, 1: begin a frame; honoured only in IDLE.
- inValid, input, 1: inEdge holds a result.
- inEdge, input, 1: edge result for the next pixel in scan order.
- inReady, output, 1: high in SCAN; a transfer occurs when inValid && inReady.
- wrEn, output, 1: RAM write strobe.
- wrAddr, output, ADDR_W: RAM address.
- wrData, output, 1: RAM data.
- lineEnd, output, 1: high together with the write of the last pixel of a line.
- busy, output, 1: high in SCAN.
- done, output, 1: one-cycle pulse after the final write.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE → SCAN on start. On that transition, latch mode and load the start position (row, col, addr) of line 0.
- SCAN → DONE on acceptance of pixel N·N−1.
- DONE → IDLE unconditionally after 1 cycle.
- Position tracking uses row, col, line index and addr registers. addr equals row·N+col at all times and is updated incrementally; no multiplier.
- LR mode:
  - Step col+1 (addr+1).
  - A line ends at col = N−1; the next line starts at (row+1, 0), addr+1.
  - N lines.
- UD mode:
  - Step row+1 (addr+N).
  - A line ends at row = N−1; the next line starts at (0, col+1), i.e. addr−(N−1)·N+1.
  - N lines.
- DL mode (anti-diagonals):
  - Line d = 0..2N−2.
  - Start position is (0, d) for d < N, else (d−N+1, N−1).
  - Step row+1, col−1 (addr+N−1).
  - A line ends when col = 0 or row = N−1.
- DR mode (diagonals):
  - Line k = 0..2N−2.
  - Start position is (0, N−1−k) for k < N, else (k−N+1, 0).
  - Step row+1, col+1 (addr+N+1).
  - A line ends when row = N−1 or col = N−1.
- Next-line start positions are computed from the line index only, never from the previous address.
- Per accepted pixel: register wrEn = 1, wrAddr = current addr, wrData = inEdge, and lineEnd = (current pixel is last in its line). Then advance the position.
- Cycles with no transfer produce wrEn = 0 and lineEnd = 0; position is held.
- start while busy or in DONE: ignored; mode changes mid-frame are ignored.
- Reset values: state IDLE; wrEn, wrAddr, wrData, lineEnd, busy, done and inReady all 0.
- resetIn mid-frame: frame is abandoned. No further writes occur; the next start begins at line 0.

## Timing
- Accept-to-write latency is 1 cycle: a transfer at edge t produces wrEn high during cycle t+1.
- One pixel per cycle sustained; no bubbles are inserted by this block.
- inReady falls in the cycle after the final acceptance. done is high in that same cycle, alongside the final wrEn.
- busy rises in the cycle after start is sampled. The earliest transfer is that cycle.
- resetIn takes priority over every other input in the same cycle.
- Frame length is exactly N·N transfers in every mode: no address is written twice and none is skipped.

## Structure
- Package scan_pkg holds:
  - the N default and NPIX = N·N;
  - the mode encodings LR, UD, DL, DR, shared with the scan counter;
  - the state enum IDLE/SCAN/DONE.
- One sub-module, scan_pos_step, is combinational. It takes (mode, row, col, addr, line) and produces the next position plus lastInLine and lastInFrame.
- The top level holds the FSM, registers and output pipeline stage.

## Test plan
- LR, N=150, continuous inValid, inEdge = addr[0]:
  - writes addr 0..22499 in order with wrData matching;
  - lineEnd at 149, 299, …, 22499;
  - done one cycle after start of the final write.
- UD: writes 0, 150, …, 22350 (lineEnd), then 1, 151, …; last write 22499 with lineEnd and done.
- DL: writes 0 (lineEnd), 1, 150 (lineEnd), 2, 151, 300 (lineEnd), …; final write 22499 (lineEnd); 299 lineEnd pulses in total.
- DR: writes 149 (lineEnd), 148, 299 (lineEnd), …; final write 22350 (lineEnd). A scoreboard confirms all 22500 addresses are hit exactly once.
- Random inValid gaps plus a start pulse and mode toggles mid-frame:
  - address sequence is identical to the gapless run;
  - wrEn = 0 on idle cycles;
  - no restart occurs.
- resetIn asserted after 1000 transfers:
  - the next cycle shows wrEn = 0, busy = 0, inReady = 0;
  - a new start in LR begins at wrAddr 0.
